debounce_edge_detector: RTL
===========================

// Module: debounce_edge_detector
// PURPOSE
//   Conditions a raw asynchronous input (push-button / external pin) before it reaches the
//   rising-edge D flip-flop stage. Synchronises din into the clk domain, rejects glitches
//   shorter than DEBOUNCE_CYCLES, and produces a clean level q (drives the flip-flop D
//   input) plus one-cycle rise/fall pulses for downstream control logic.
// PARAMETERS
//   SYNC_STAGES      2   number of synchroniser flops; legal range >= 2
//   DEBOUNCE_CYCLES  4   consecutive identical synchronised samples required to accept a
//                        change; legal range >= 1
//   CNT_WIDTH        derived localparam = $clog2(DEBOUNCE_CYCLES+1); not overridable
// PORTS
//   clk            in   1  single clock; all state updates on its rising edge
//   async_reset_n  in   1  asynchronous reset, active-low; release assumed synchronous to clk
//   din            in   1  raw asynchronous input, may bounce
//   q              out  1  debounced level, registered
//   rise_pulse     out  1  high for exactly one cycle when q goes 0->1
//   fall_pulse     out  1  high for exactly one cycle when q goes 1->0
//   busy           out  1  high while a candidate change is being qualified (WAIT_* states)
// BEHAVIOUR
//   Reset (async_reset_n=0, takes effect immediately, no clock needed):
//     sync chain=0, cnt=0, state=IDLE_LOW, q=0, rise_pulse=0, fall_pulse=0, busy=0.
//   Synchroniser: s[0]<=din, s[i]<=s[i-1]; sync_in = s[SYNC_STAGES-1].
//   FSM (4 states, registered):
//     IDLE_LOW : sync_in=1 -> WAIT_HIGH, cnt<=1 (DEBOUNCE_CYCLES=1: flip q directly, -> IDLE_HIGH)
//     WAIT_HIGH: sync_in=0 -> IDLE_LOW, cnt<=0 (bounce rejected, no pulse)
//                sync_in=1 & cnt=DEBOUNCE_CYCLES-1 -> IDLE_HIGH, q<=1, rise_pulse<=1, cnt<=0
//                else cnt<=cnt+1
//     IDLE_HIGH / WAIT_LOW: mirror image with polarity inverted, fall_pulse instead.
//   Pulses: registered, asserted on the same edge q changes, cleared on the next edge.
//   busy = (state==WAIT_HIGH)|(state==WAIT_LOW), registered with state.
//   Latency: q changes on the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge that samples din
//     at its new value, counting the first sampling edge as 1 (defaults: 6th edge).
//   Boundaries:
//     - cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around possible.
//     - Bounce on the qualifying edge itself: change rejected, state returns to IDLE, qualify
//       restarts from 1 on the next differing sample.
//     - rise_pulse and fall_pulse are never high together; never two pulses on adjacent edges
//       when DEBOUNCE_CYCLES>=2.
//     - Reset asserted mid-qualification: all outputs clear immediately; no pulse emitted.
//     - din held constant through reset release: no pulse unless din=1 (rise after latency).
// STRUCTURE
//   debounce_defs.vh (shared include): state encodings ST_IDLE_LOW=2'b00, ST_WAIT_HIGH=2'b01,
//     ST_IDLE_HIGH=2'b11, ST_WAIT_LOW=2'b10 (Gray ordering, single-bit transitions).
//   Sub-module sync_chain #(STAGES) (clk, async_reset_n, d, q): reusable N-flop synchroniser.
//   Top level holds FSM, counter and output registers only.
// TESTING  (clk period 80 ns, defaults unless stated)
//   1 Reset: async_reset_n=0 at t=0 with din=1 -> q=0, pulses=0, busy=0 with no clk edge.
//   2 Clean rise: release reset, din 0->1 and held -> q=1 and rise_pulse=1 on 6th sampling
//     edge; rise_pulse=0 on 7th; busy high from 3rd to 5th edge.
//   3 Glitch: din=1 for 2 cycles then 0 -> q stays 0, no pulse, busy returns to 0.
//   4 Bounce: din 1,0,1,1,1,1,1 per cycle -> single rise_pulse, q=1 six edges after last 0->1.
//   5 Fall + reset mid-wait: from q=1, drop din, assert async_reset_n=0 at 3rd edge
//     -> q=0 immediately, fall_pulse never asserted.
//   6 DEBOUNCE_CYCLES=1, SYNC_STAGES=3: din 0->1 -> q=1 on 4th sampling edge, rise_pulse 1 cycle.

Source files
------------

// File: rtl/debounce_edge_detector_pkg.sv
// ---------------------------------------------------------------------------
// debounce_edge_detector_pkg
//   Shared definitions for the debounce / edge-detect block.
//   - state_t : FSM state encoding. Gray ordered around the cycle
//               IDLE_LOW -> WAIT_HIGH -> IDLE_HIGH -> WAIT_LOW -> IDLE_LOW,
//               so every legal transition flips exactly one state bit.
//   - is_wait : true while a candidate level change is being qualified.
//   - state_level : debounced level implied by a state (bit 1 of the code).
// ---------------------------------------------------------------------------
package debounce_edge_detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE_LOW  = 2'b00,
    ST_WAIT_HIGH = 2'b01,
    ST_IDLE_HIGH = 2'b11,
    ST_WAIT_LOW  = 2'b10
  } state_t;

  // WAIT_HIGH (01) and WAIT_LOW (10) are the two codes whose bits differ.
  function automatic logic is_wait(input state_t st);
    return (st == ST_WAIT_HIGH) || (st == ST_WAIT_LOW);
  endfunction

  // In both states of the "high" half of the cycle (IDLE_HIGH, WAIT_LOW)
  // the accepted level is still 1; the Gray code puts that in bit 1.
  function automatic logic state_level(input state_t st);
    return (st == ST_IDLE_HIGH) || (st == ST_WAIT_LOW);
  endfunction

endpackage

// File: rtl/debounce_edge_detector_sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
//   Reusable N-flop synchroniser bringing an asynchronous bit into the clk
//   domain. d is sampled by the first flop; q is the output of the last.
//   Ports:
//     clk           in  1  sampling clock
//     async_reset_n in  1  asynchronous active-low reset, clears every flop
//     d             in  1  asynchronous input
//     q             out 1  synchronised output, STAGES cycles behind d
//   Parameters:
//     STAGES  number of flops, must be >= 2
// ---------------------------------------------------------------------------
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic async_reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_p;

  // Shift register: sync_p[0] is the metastability-exposed flop, the
  // remaining flops give it time to resolve before the value is used.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[STAGES-2:0], d};
    end
  end

  assign q = sync_p[STAGES-1];

endmodule

// File: rtl/debounce_edge_detector.sv
// ---------------------------------------------------------------------------
// debounce_edge_detector
//   Conditions a raw asynchronous input (push-button / external pin).
//   The input is synchronised, then a 4-state FSM accepts a level change
//   only after DEBOUNCE_CYCLES consecutive identical synchronised samples.
//   The accepted level drives q; one-cycle rise/fall pulses mark changes.
//
//   Ports:
//     clk            in  1  single clock, rising edge
//     async_reset_n  in  1  asynchronous active-low reset
//     din            in  1  raw asynchronous input, may bounce
//     q              out 1  debounced level, registered
//     rise_pulse     out 1  one-cycle pulse when q goes 0->1
//     fall_pulse     out 1  one-cycle pulse when q goes 1->0
//     busy           out 1  high while a candidate change is qualifying
//
//   Parameters:
//     SYNC_STAGES      synchroniser depth, >= 2
//     DEBOUNCE_CYCLES  consecutive samples needed to accept a change, >= 1
//
//   Latency: q changes on the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge
//   that samples din at its new value.
// ---------------------------------------------------------------------------
module debounce_edge_detector
  import debounce_edge_detector_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic async_reset_n,
  input  logic din,
  output logic q,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  // With a single required sample there is nothing to qualify: the first
  // differing sample flips q directly and the WAIT states are never used.
  localparam bit DIRECT_FLIP = (DEBOUNCE_CYCLES == 1);

  logic                 sync_in;
  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 q_nxt;
  logic                 rise_nxt;
  logic                 fall_nxt;
  logic                 busy_nxt;

  // ---- stage 0: synchronise din into the clk domain ----
  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .d             (din),
    .q             (sync_in)
  );

  // ---- stage 1: qualification FSM, next-state and output decode ----
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    q_nxt     = q;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;

    unique case (state)
      ST_IDLE_LOW: begin
        if (sync_in) begin
          if (DIRECT_FLIP) begin
            state_nxt = ST_IDLE_HIGH;
            q_nxt     = 1'b1;
            rise_nxt  = 1'b1;
            cnt_nxt   = '0;
          end else begin
            // This sample is the first of the run.
            state_nxt = ST_WAIT_HIGH;
            cnt_nxt   = CNT_ONE;
          end
        end
      end

      ST_WAIT_HIGH: begin
        if (!sync_in) begin
          // Bounce: drop the candidate, restart from scratch next time.
          state_nxt = ST_IDLE_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_IDLE_HIGH;
          q_nxt     = 1'b1;
          rise_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      ST_IDLE_HIGH: begin
        if (!sync_in) begin
          if (DIRECT_FLIP) begin
            state_nxt = ST_IDLE_LOW;
            q_nxt     = 1'b0;
            fall_nxt  = 1'b1;
            cnt_nxt   = '0;
          end else begin
            state_nxt = ST_WAIT_LOW;
            cnt_nxt   = CNT_ONE;
          end
        end
      end

      ST_WAIT_LOW: begin
        if (sync_in) begin
          state_nxt = ST_IDLE_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_IDLE_LOW;
          q_nxt     = 1'b0;
          fall_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      default: begin
        state_nxt = ST_IDLE_LOW;
        cnt_nxt   = '0;
        q_nxt     = 1'b0;
      end
    endcase

    // busy is registered alongside state, so decode it from the next state.
    busy_nxt = is_wait(state_nxt);
  end

  // ---- stage 2: state, counter and output registers ----
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state      <= ST_IDLE_LOW;
      cnt        <= '0;
      q          <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      q          <= q_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule
